// File: rtl/dual_port_ram_pkg.sv
// dual_port_ram_pkg
// Shared types and helpers for the byte-enabled dual-port RAM.
//   ram_state_t    : clear-sequencer states (CLEAR, READY)
//   byte_merge     : lane-wise merge of a new word into an old word
//   READ_FIRST     : collision read policy (reads return pre-write data)
//   MAX_DATA_WIDTH : widest word byte_merge can handle
package dual_port_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_t;

  localparam bit READ_FIRST     = 1'b1;
  localparam int MAX_DATA_WIDTH = 1024;
  localparam int MAX_BYTES      = MAX_DATA_WIDTH / 8;

  // Callers narrower than MAX_DATA_WIDTH size-cast their operands in and the
  // result back out; unused upper lanes fold away in synthesis.
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] oldWord,
    input logic [MAX_DATA_WIDTH-1:0] newWord,
    input logic [MAX_BYTES-1:0]      byteEn
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = oldWord;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (byteEn[i]) merged[8*i +: 8] = newWord[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dual_port_ram_be_clear_fsm.sv
// ram_clear_fsm
// Post-reset clear sequencer: sweeps every word once, then reports ready.
//   clock, reset : clock and synchronous active-high reset
//   clr_we       : write strobe for the sweep word
//   clr_addr     : address being cleared this cycle
//   ready        : registered, high once the array accepts port accesses
module ram_clear_fsm
  import dual_port_ram_pkg::*;
#(
  parameter int SIZE           = 1024,
  parameter int ADDR_WIDTH     = $clog2(SIZE),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  ready
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

  ram_state_t            state_q;
  logic [ADDR_WIDTH-1:0] clearPtr_q;
  logic                  ready_q;

  // The last sweep write and the move to READY share one edge, so ready
  // goes high exactly SIZE cycles after reset is released.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= CLEAR;
      clearPtr_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (!CLEAR_ON_RESET || (clearPtr_q == LAST_ADDR)) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end else begin
            clearPtr_q <= clearPtr_q + 1'b1;
          end
        end
        READY: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= CLEAR;
        end
      endcase
    end
  end

  assign clr_we   = (state_q == CLEAR) && CLEAR_ON_RESET && !reset;
  assign clr_addr = clearPtr_q;
  assign ready    = ready_q;

endmodule

// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be
// True dual-port word RAM with per-byte write enables, 0/1-cycle read
// latency, read-first collision policy and a post-reset fill sweep.
//   clock, reset          : clock and synchronous active-high reset
//   ready                 : array accepts accesses
//   collision             : one-cycle pulse after a same-address conflict
//   en/we/be/addr/wdata_x : port x access enable, write, byte enables,
//                           word address and write data
//   rdata_x               : port x read data
module dual_port_ram_be
  import dual_port_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    SIZE           = 1024,
  parameter int                    ADDR_WIDTH     = $clog2(SIZE),
  parameter int                    READ_LATENCY   = 1,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE     = '1
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    ready,
  output logic                    collision,
  input  logic                    en_a,
  input  logic                    we_a,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   wdata_a,
  output logic [DATA_WIDTH-1:0]   rdata_a,
  input  logic                    en_b,
  input  logic                    we_b,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   wdata_b,
  output logic [DATA_WIDTH-1:0]   rdata_b
);

  if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : gen_bad_latency
    $error("dual_port_ram_be: READ_LATENCY must be 0 or 1");
  end
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : gen_bad_width
    $error("dual_port_ram_be: DATA_WIDTH must be a multiple of 8 within MAX_DATA_WIDTH");
  end
  if (!READ_FIRST) begin : gen_bad_policy
    $error("dual_port_ram_be: only the read-first policy is implemented");
  end

  localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH + 1)'(SIZE);

  logic [DATA_WIDTH-1:0] mem [SIZE];

  logic                  clrWe;
  logic [ADDR_WIDTH-1:0] clrAddr;
  logic                  inRangeA, inRangeB, sameAddr, wrA, wrB;
  logic [DATA_WIDTH-1:0] memRdA, memRdB, mergedA, mergedB, baseA;
  logic                  collision_q;

  ram_clear_fsm #(
    .SIZE           (SIZE),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_fsm (
    .clock    (clock),
    .reset    (reset),
    .clr_we   (clrWe),
    .clr_addr (clrAddr),
    .ready    (ready)
  );

  assign inRangeA = ({1'b0, addr_a} < SIZE_W);
  assign inRangeB = ({1'b0, addr_b} < SIZE_W);
  assign sameAddr = (addr_a == addr_b);
  assign wrA      = ready && en_a && we_a && inRangeA;
  assign wrB      = ready && en_b && we_b && inRangeB;

  // On a same-address dual write, A's lanes are merged on top of B's merge,
  // so A wins overlapping lanes and each port keeps its exclusive lanes.
  always_comb begin
    memRdA  = inRangeA ? mem[addr_a] : '0;
    memRdB  = inRangeB ? mem[addr_b] : '0;
    mergedB = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(memRdB),
                                     MAX_DATA_WIDTH'(wdata_b),
                                     MAX_BYTES'(be_b)));
    baseA   = (wrB && sameAddr) ? mergedB : memRdA;
    mergedA = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(baseA),
                                     MAX_DATA_WIDTH'(wdata_a),
                                     MAX_BYTES'(be_a)));
  end

  // The sweep and port writes never overlap because ports are gated by ready.
  always_ff @(posedge clock) begin
    if (clrWe) begin
      mem[clrAddr] <= FILL_VALUE;
    end else begin
      if (wrB && !(wrA && sameAddr)) mem[addr_b] <= mergedB;
      if (wrA)                       mem[addr_a] <= mergedA;
    end
  end

  // Requiring addr_a in range also excludes out-of-range pairs, since the
  // addresses are equal.
  always_ff @(posedge clock) begin
    if (reset) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= ready && en_a && en_b && sameAddr && (we_a || we_b) && inRangeA;
    end
  end

  assign collision = collision_q;

  if (READ_LATENCY == 1) begin : gen_reg_read
    logic [DATA_WIDTH-1:0] rdataA_q, rdataB_q;

    // Loading on every enabled access, writes included, gives read-first.
    always_ff @(posedge clock) begin
      if (reset || !ready) begin
        rdataA_q <= '0;
        rdataB_q <= '0;
      end else begin
        if (en_a) rdataA_q <= memRdA;
        if (en_b) rdataB_q <= memRdB;
      end
    end

    assign rdata_a = rdataA_q;
    assign rdata_b = rdataB_q;
  end else begin : gen_comb_read
    assign rdata_a = ready ? memRdA : '0;
    assign rdata_b = ready ? memRdB : '0;
  end

endmodule

// File: tb/tb_dual_port_ram_be.sv
// tb_dual_port_ram_be
// Directed bench for dual_port_ram_be with SIZE=12, 32-bit words.
//   dut  : READ_LATENCY=1, CLEAR_ON_RESET=1
//   dut0 : READ_LATENCY=0, CLEAR_ON_RESET=0
module tb_dual_port_ram_be;

  localparam int DW   = 32;
  localparam int SZ   = 12;
  localparam int AW   = 4;
  localparam logic [DW-1:0] FILL = 32'hFFFF_FFFF;

  logic          clock = 1'b0;
  logic          reset, ready, collision;
  logic          en_a, we_a, en_b, we_b;
  logic [3:0]    be_a, be_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b, rdata_a, rdata_b;

  logic          reset0, ready0, collision0;
  logic          en_a0, we_a0, en_b0, we_b0;
  logic [3:0]    be_a0, be_b0;
  logic [AW-1:0] addr_a0, addr_b0;
  logic [DW-1:0] wdata_a0, wdata_b0, rdata_a0, rdata_b0;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  dual_port_ram_be #(
    .DATA_WIDTH (DW), .SIZE (SZ), .READ_LATENCY (1),
    .CLEAR_ON_RESET (1'b1), .FILL_VALUE (FILL)
  ) dut (
    .clock (clock), .reset (reset), .ready (ready), .collision (collision),
    .en_a (en_a), .we_a (we_a), .be_a (be_a), .addr_a (addr_a),
    .wdata_a (wdata_a), .rdata_a (rdata_a),
    .en_b (en_b), .we_b (we_b), .be_b (be_b), .addr_b (addr_b),
    .wdata_b (wdata_b), .rdata_b (rdata_b)
  );

  dual_port_ram_be #(
    .DATA_WIDTH (DW), .SIZE (SZ), .READ_LATENCY (0),
    .CLEAR_ON_RESET (1'b0), .FILL_VALUE (FILL)
  ) dut0 (
    .clock (clock), .reset (reset0), .ready (ready0), .collision (collision0),
    .en_a (en_a0), .we_a (we_a0), .be_a (be_a0), .addr_a (addr_a0),
    .wdata_a (wdata_a0), .rdata_a (rdata_a0),
    .en_b (en_b0), .we_b (we_b0), .be_b (be_b0), .addr_b (addr_b0),
    .wdata_b (wdata_b0), .rdata_b (rdata_b0)
  );

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic ea, input logic wa, input logic [3:0] ba,
                               input logic [AW-1:0] aa, input logic [DW-1:0] da,
                               input logic eb, input logic wb, input logic [3:0] bb,
                               input logic [AW-1:0] ab, input logic [DW-1:0] db);
    en_a = ea; we_a = wa; be_a = ba; addr_a = aa; wdata_a = da;
    en_b = eb; we_b = wb; be_b = bb; addr_b = ab; wdata_b = db;
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, 1'b0, 4'h0, '0, '0);
    tick(); tick();
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_ready: got %b expected 0", ready);
    end
    vectors++;
    if (collision !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_collision: got %b expected 0", collision);
    end
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd11, '0, 1'b1, 1'b0, 4'h0, 4'd11, '0);
    cnt = 0;
    while (ready !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
      if (cnt == 11) begin
        vectors++;
        if (rdata_a !== 32'h0) begin
          miscompares++; $display("[TB] FAIL clear_rdata_a: got %h expected 00000000", rdata_a);
        end
      end
    end
    vectors++;
    if (cnt != 12) begin
      miscompares++; $display("[TB] FAIL sweep_length: got %0d cycles expected 12", cnt);
    end
    tick();
    vectors++;
    if (rdata_a !== FILL) begin
      miscompares++; $display("[TB] FAIL fill_read_a11: got %h expected %h", rdata_a, FILL);
    end
    vectors++;
    if (rdata_b !== FILL) begin
      miscompares++; $display("[TB] FAIL fill_read_b11: got %h expected %h", rdata_b, FILL);
    end
  endtask

  task automatic test_byte_write();
    applyStimulus(1'b1, 1'b1, 4'b0101, 4'd3, 32'h1122_3344, 1'b1, 1'b0, 4'h0, 4'd3, '0);
    tick();
    vectors++;
    if (rdata_b !== FILL) begin
      miscompares++; $display("[TB] FAIL cross_read_first_b: got %h expected %h", rdata_b, FILL);
    end
    vectors++;
    if (rdata_a !== FILL) begin
      miscompares++; $display("[TB] FAIL write_port_read_first_a: got %h expected %h", rdata_a, FILL);
    end
    vectors++;
    if (collision !== 1'b1) begin
      miscompares++; $display("[TB] FAIL write_read_collision: got %b expected 1", collision);
    end
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd3, '0, 1'b0, 1'b0, 4'h0, 4'd3, '0);
    tick();
    vectors++;
    if (rdata_a !== 32'hFF22_FF44) begin
      miscompares++; $display("[TB] FAIL byte_merge_a3: got %h expected ff22ff44", rdata_a);
    end
    vectors++;
    if (collision !== 1'b0) begin
      miscompares++; $display("[TB] FAIL collision_pulse_end: got %b expected 0", collision);
    end
    vectors++;
    if (rdata_b !== FILL) begin
      miscompares++; $display("[TB] FAIL rdata_b_hold: got %h expected %h", rdata_b, FILL);
    end
  endtask

  task automatic test_dual_write();
    applyStimulus(1'b1, 1'b1, 4'b0011, 4'd5, 32'hAAAA_AAAA, 1'b1, 1'b1, 4'b0110, 4'd5, 32'hBBBB_BBBB);
    tick();
    vectors++;
    if (collision !== 1'b1) begin
      miscompares++; $display("[TB] FAIL dual_write_collision: got %b expected 1", collision);
    end
    applyStimulus(1'b1, 1'b1, 4'b1111, 4'd1, 32'h0000_0001, 1'b1, 1'b1, 4'b1000, 4'd2, 32'h1234_5678);
    tick();
    vectors++;
    if (collision !== 1'b0) begin
      miscompares++; $display("[TB] FAIL collision_one_cycle: got %b expected 0", collision);
    end
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd5, '0, 1'b1, 1'b0, 4'h0, 4'd2, '0);
    tick();
    vectors++;
    if (rdata_a !== 32'hFFBB_AAAA) begin
      miscompares++; $display("[TB] FAIL dual_write_merge_a5: got %h expected ffbbaaaa", rdata_a);
    end
    vectors++;
    if (rdata_b !== 32'h12FF_FFFF) begin
      miscompares++; $display("[TB] FAIL port_b_write_a2: got %h expected 12ffffff", rdata_b);
    end
  endtask

  task automatic test_read_read();
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd7, '0, 1'b1, 1'b0, 4'h0, 4'd7, '0);
    tick();
    vectors++;
    if (collision !== 1'b0) begin
      miscompares++; $display("[TB] FAIL read_read_collision: got %b expected 0", collision);
    end
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'd7, 32'h0, 1'b0, 1'b0, 4'h0, 4'd0, '0);
    tick();
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd7, '0, 1'b0, 1'b0, 4'h0, 4'd0, '0);
    tick();
    vectors++;
    if (rdata_a !== FILL) begin
      miscompares++; $display("[TB] FAIL zero_be_noop: got %h expected %h", rdata_a, FILL);
    end
    applyStimulus(1'b1, 1'b1, 4'hF, 4'd13, 32'h0, 1'b1, 1'b1, 4'hF, 4'd13, 32'h0);
    tick();
    vectors++;
    if (collision !== 1'b0) begin
      miscompares++; $display("[TB] FAIL out_of_range_collision: got %b expected 0", collision);
    end
    applyStimulus(1'b1, 1'b0, 4'h0, 4'd13, '0, 1'b1, 1'b0, 4'h0, 4'd1, '0);
    tick();
    vectors++;
    if (rdata_a !== 32'h0) begin
      miscompares++; $display("[TB] FAIL out_of_range_read: got %h expected 00000000", rdata_a);
    end
    vectors++;
    if (rdata_b !== 32'h0000_0001) begin
      miscompares++; $display("[TB] FAIL in_range_read_a1: got %h expected 00000001", rdata_b);
    end
  endtask

  task automatic test_reset_midsweep();
    int cnt;
    applyStimulus(1'b0, 1'b0, 4'h0, '0, '0, 1'b0, 1'b0, 4'h0, '0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (6) tick();
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL midsweep_ready: got %b expected 0", ready);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    vectors++;
    if (cnt != 12) begin
      miscompares++; $display("[TB] FAIL restart_sweep_length: got %0d cycles expected 12", cnt);
    end
    for (int i = 0; i < SZ; i++) begin
      applyStimulus(1'b1, 1'b0, 4'h0, AW'(i), '0, 1'b0, 1'b0, 4'h0, '0, '0);
      tick();
      vectors++;
      if (rdata_a !== FILL) begin
        miscompares++; $display("[TB] FAIL refill_word_%0d: got %h expected %h", i, rdata_a, FILL);
      end
    end
  endtask

  task automatic test_latency0();
    en_a0 = 1'b0; we_a0 = 1'b0; be_a0 = 4'h0; addr_a0 = '0; wdata_a0 = '0;
    en_b0 = 1'b0; we_b0 = 1'b0; be_b0 = 4'h0; addr_b0 = '0; wdata_b0 = '0;
    reset0 = 1'b1;
    tick();
    vectors++;
    if (rdata_a0 !== 32'h0) begin
      miscompares++; $display("[TB] FAIL lat0_reset_rdata: got %h expected 00000000", rdata_a0);
    end
    reset0 = 1'b0;
    tick();
    vectors++;
    if (ready0 !== 1'b1) begin
      miscompares++; $display("[TB] FAIL lat0_ready: got %b expected 1", ready0);
    end
    en_a0 = 1'b1; we_a0 = 1'b1; be_a0 = 4'hF; addr_a0 = 4'd0; wdata_a0 = 32'hDEAD_BEEF;
    tick();
    en_a0 = 1'b0; we_a0 = 1'b0;
    #1;
    vectors++;
    if (rdata_a0 !== 32'hDEAD_BEEF) begin
      miscompares++; $display("[TB] FAIL lat0_comb_read_a: got %h expected deadbeef", rdata_a0);
    end
    en_a0 = 1'b1; we_a0 = 1'b1; be_a0 = 4'b1100; wdata_a0 = 32'hCAFE_F00D;
    #1;
    vectors++;
    if (rdata_b0 !== 32'hDEAD_BEEF) begin
      miscompares++; $display("[TB] FAIL lat0_cross_read_first: got %h expected deadbeef", rdata_b0);
    end
    tick();
    en_a0 = 1'b0; we_a0 = 1'b0;
    #1;
    vectors++;
    if (rdata_b0 !== 32'hCAFE_BEEF) begin
      miscompares++; $display("[TB] FAIL lat0_byte_write: got %h expected cafebeef", rdata_b0);
    end
  endtask

  initial begin
    reset0 = 1'b1;
    en_a0 = 1'b0; we_a0 = 1'b0; be_a0 = 4'h0; addr_a0 = '0; wdata_a0 = '0;
    en_b0 = 1'b0; we_b0 = 1'b0; be_b0 = 4'h0; addr_b0 = '0; wdata_b0 = '0;
    test_reset();
    test_byte_write();
    test_dual_write();
    test_read_read();
    test_reset_midsweep();
    test_latency0();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
